// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-mode selectors and the widest supported payload.
package uart_pkg;

  localparam int MAX_DATA_BITS = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SYNC   = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;
  localparam state_t ST_STOP   = 3'd5;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register, driven by bit ticks
// derived from the rising edges of an external baud clock.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, baud generator off, waiting for a held byte
// SYNC   | baud generator running, waiting for first tick to align
// START  | start bit (0) for one bit period
// DATA   | payload bits, LSB first, one per tick
// PARITY | optional parity bit (even or odd over the payload)
// STOP   | STOP_BITS stop bits (1); back-to-back reload on final tick
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  output logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(MAX_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  // The stop counter only needs to tell the first of two stop bits apart.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 hold_full_q, hold_full_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 baud_en_q, baud_en_d;
  logic                 baud_prev_q;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 accept;
  logic                 load;

  assign tick     = baud_clk & ~baud_prev_q;
  assign accept   = tx_valid & ~hold_full_q;
  assign tx_ready = ~hold_full_q;
  assign baud_en  = baud_en_q;
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE) | hold_full_q;

  // Frame sequencing: next state, bit index, stop count and generator enable.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    baud_en_d  = baud_en_q;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load      = 1'b1;
          baud_en_d = 1'b1;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (tick) state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            stop_cnt_d = 1'b0;
            state_d    = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = 1'b0;
            if (hold_full_q) begin
              // Reload straight into START: the generator is already phased.
              load    = 1'b1;
              state_d = ST_START;
            end else begin
              baud_en_d = 1'b0;
              state_d   = ST_IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        baud_en_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Holding register and shift register: accept and load may coincide.
  always_comb begin
    hold_d      = hold_q;
    shift_d     = shift_q;
    if (accept) hold_d = tx_data;
    if (load) shift_d = hold_q;
    hold_full_d = (hold_full_q & ~load) | accept;
  end

  // Serial line value for the next cycle, registered so the pin never glitches.
  always_comb begin
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[idx_d];
      ST_PARITY: tx_d = (^shift_d) ^ (PARITY_MODE == PAR_ODD);
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      stop_cnt_q  <= 1'b0;
      baud_en_q   <= 1'b0;
      baud_prev_q <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      stop_cnt_q  <= stop_cnt_d;
      baud_en_q   <= baud_en_d;
      baud_prev_q <= baud_clk;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O1), each with its own
// baud generator (4 clk per half period) and a line monitor that decodes
// frames against a scoreboard of accepted bytes.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data_a [3] = '{8'h00, 8'h00, 8'h00};
  logic       tx_valid_a[3] = '{1'b0, 1'b0, 1'b0};
  logic       baud_clk_a[3] = '{1'b0, 1'b0, 1'b0};
  logic       tx_ready_w[3];
  logic       tx_w      [3];
  logic       busy_w    [3];
  logic       baud_en_w [3];
  bit         free_run = 1'b0;

  logic [7:0] exp_mem[3][64];
  int         wr[3] = '{0, 0, 0};
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level of frame position b: start, 8 data LSB first, parity, stops.
  function automatic logic frame_bit(int pm, logic [7:0] d, int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && pm != 0) return (^d) ^ (pm == 2);
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_i
    localparam int PM = g;
    localparam int SB = (g == 1) ? 2 : 1;
    localparam int NB = 9 + ((PM != 0) ? 1 : 0) + SB;

    uart_tx #(.DATA_BITS(8), .PARITY_MODE(PM), .STOP_BITS(SB)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_clk (baud_clk_a[g]),
      .baud_en  (baud_en_w[g]),
      .tx_data  (tx_data_a[g]),
      .tx_valid (tx_valid_a[g]),
      .tx_ready (tx_ready_w[g]),
      .tx       (tx_w[g]),
      .busy     (busy_w[g])
    );

    int bcnt = 0;
    always @(negedge clk) begin
      if (baud_en_w[g] || free_run) begin
        bcnt++;
        if (bcnt == 4) begin
          bcnt = 0;
          baud_clk_a[g] = ~baud_clk_a[g];
        end
      end else begin
        bcnt = 0;
        baud_clk_a[g] = 1'b0;
      end
    end

    int         rd = 0;
    int         cnt = 0;
    int         good = 0;
    int         gap = 0;
    int         b = 0;
    int         gap_mem[64];
    bit         active = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] dec = 8'h00;
    logic       last_par = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        active = 1'b0;
        rd     = wr[g];
        gap    = 0;
      end else if (!active) begin
        if (tx_w[g] === 1'b0) begin
          chk($sformatf("u%0d_frame_expected", g), 32'(rd != wr[g]), 32'd1);
          cur            = exp_mem[g][rd % 64];
          gap_mem[rd % 64] = gap;
          gap            = 0;
          active         = 1'b1;
          cnt            = 0;
          good           = 0;
          dec            = 8'h00;
        end else begin
          gap++;
        end
      end
      if (rst_n && active) begin
        b = cnt / 8;
        if (tx_w[g] === frame_bit(PM, cur, b)) good++;
        if (cnt % 8 == 3) begin
          if (b >= 1 && b <= 8) dec[b-1] = tx_w[g];
          if (b == 9 && PM != 0) begin
            last_par = tx_w[g];
            chk($sformatf("u%0d_parity", g), 32'(tx_w[g]), 32'(frame_bit(PM, cur, 9)));
          end
        end
        if (cnt % 8 == 7) begin
          chk($sformatf("u%0d_bit%0d_len", g, b), good, 8);
          good = 0;
          if (b == NB - 1) begin
            chk($sformatf("u%0d_data", g), 32'(dec), 32'(cur));
            rd++;
            active = 1'b0;
          end
        end
        cnt++;
      end
    end
  end

  task automatic send(int k, logic [7:0] d);
    int n = 0;
    bit ok = 1'b0;
    @(negedge clk);
    tx_data_a[k]  = d;
    tx_valid_a[k] = 1'b1;
    while (!ok && n < 3000) begin
      ok = (tx_ready_w[k] === 1'b1);
      @(posedge clk);
      n++;
      if (!ok) @(negedge clk);
    end
    #1 tx_valid_a[k] = 1'b0;
    if (ok) begin
      exp_mem[k][wr[k] % 64] = d;
      wr[k]++;
    end else begin
      chk($sformatf("u%0d_accept_timeout", k), 32'd1, 32'd0);
    end
  endtask

  task automatic wait_idle(int k);
    int n = 0;
    @(negedge clk);
    while (busy_w[k] !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk($sformatf("u%0d_idle_timeout", k), 32'd1, 32'd0);
    chk($sformatf("u%0d_idle_baud_en", k), 32'(baud_en_w[k]), 32'd0);
    chk($sformatf("u%0d_idle_tx", k), 32'(tx_w[k]), 32'd1);
    chk($sformatf("u%0d_idle_ready", k), 32'(tx_ready_w[k]), 32'd1);
  endtask

  // Cycles from start-bit fall to busy dropping, for frame length checks.
  task automatic frame_len(int k, logic [7:0] d, int want);
    int n = 0;
    int len = 0;
    send(k, d);
    while (tx_w[k] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (busy_w[k] !== 1'b0 && len < 400) begin
      @(negedge clk);
      len++;
    end
    chk($sformatf("u%0d_frame_cycles", k), len, want);
  endtask

  initial begin
    int         bad;
    int         n;
    int         idx2;
    logic       prev;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [7:0] c_byte;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_tx", k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("u%0d_rst_baud_en", k), 32'(baud_en_w[k]), 32'd0);
      chk($sformatf("u%0d_rst_ready", k), 32'(tx_ready_w[k]), 32'd1);
      chk($sformatf("u%0d_rst_busy", k), 32'(busy_w[k]), 32'd0);
    end
    #2 rst_n = 1'b1;

    // Ticks while idle must not start anything.
    free_run = 1'b1;
    bad = 0;
    repeat (64) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || baud_en_w[0] !== 1'b0 || busy_w[0] !== 1'b0) bad++;
    end
    free_run = 1'b0;
    chk("idle_ticks_ignored", bad, 0);

    // Single 8N1 byte.
    send(0, 8'h55);
    wait_idle(0);

    // Parity and stop-bit variants with 0xA3 (four ones).
    frame_len(1, 8'hA3, 96);
    chk("even_parity_A3", 32'(gen_i[1].last_par), 32'd0);
    wait_idle(1);
    frame_len(2, 8'hA3, 88);
    chk("odd_parity_A3", 32'(gen_i[2].last_par), 32'd1);
    wait_idle(2);

    // Back-to-back bytes: reload coincides with the next start bit.
    send(0, 8'h01);
    idx2 = wr[0];
    send(0, 8'h02);
    @(negedge clk);
    chk("b2b_ready_low", 32'(tx_ready_w[0]), 32'd0);
    chk("b2b_busy", 32'(busy_w[0]), 32'd1);
    n = 0;
    prev = 1'b1;
    while (tx_ready_w[0] !== 1'b1 && n < 300) begin
      prev = tx_w[0];
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("b2b_ready_timeout", 32'd1, 32'd0);
    chk("b2b_reload_start", 32'(tx_w[0]), 32'd0);
    chk("b2b_stop_before", 32'(prev), 32'd1);
    wait_idle(0);
    chk("b2b_gap", gen_i[0].gap_mem[idx2 % 64], 0);

    // Held byte must survive tx_valid with changing data while full.
    a_byte = 8'($urandom);
    b_byte = 8'($urandom);
    c_byte = 8'($urandom);
    send(0, a_byte);
    send(0, b_byte);
    @(negedge clk);
    tx_valid_a[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      tx_data_a[0] = 8'($urandom);
      if (tx_ready_w[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("hold_ready_low", bad, 0);
    send(0, c_byte);
    wait_idle(0);

    // Randomized traffic on all three instances concurrently.
    for (int k = 0; k < 3; k++) begin
      automatic int kk = k;
      fork
        begin
          for (int i = 0; i < 6; i++) begin
            send(kk, 8'($urandom));
            repeat ($urandom_range(0, 120)) @(negedge clk);
          end
        end
      join_none
    end
    wait fork;
    for (int k = 0; k < 3; k++) wait_idle(k);

    // Reset mid-frame in the DATA phase of 0xFF.
    send(0, 8'hFF);
    repeat (36) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    chk("pre_rst_baud_en", 32'(baud_en_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_baud_en", 32'(baud_en_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_ready", 32'(tx_ready_w[0]), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(0, 8'h00);
    wait_idle(0);

    repeat (4) @(negedge clk);
    chk("u0_drained", gen_i[0].rd, wr[0]);
    chk("u1_drained", gen_i[1].rd, wr[1]);
    chk("u2_drained", gen_i[2].rd, wr[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
